// File: rtl/pa_ctrl_pkg.sv
// Shared definitions for the privacy-amplification session controller:
// FSM state encoding, error codes, BRAM geometry and default length limits.
package pa_ctrl_pkg;

  // Session FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    CHECK    = 3'd2,
    LAUNCH   = 3'd3,
    RUN      = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } pa_state_e;

  // Failure reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_ENGINE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Reconciled-key BRAM: two halves of 16384 words x 64 bits
  localparam int unsigned BRAM_HALF_DEPTH = 16384;
  localparam int unsigned BRAM_WORD_W     = 64;

  // Key lengths must be whole BRAM words and fit in one half
  localparam int unsigned LEN_ALIGN_BITS = $clog2(BRAM_WORD_W);
  localparam int unsigned LEN_MIN_DEF    = 1024;
  localparam int unsigned LEN_MAX_DEF    = BRAM_HALF_DEPTH * BRAM_WORD_W;

  // A length is usable when inside [lo, hi] and a multiple of the word width
  function automatic logic len_is_legal(input logic [31:0] len,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (len >= lo) && (len <= hi) && (len[LEN_ALIGN_BITS-1:0] == '0);
  endfunction

endpackage

// File: rtl/pa_watchdog.sv
// Session watchdog: clearable up-counter that raises expire once it has
// counted LIMIT-1 enabled cycles since the last clear. It holds at that
// value until cleared again, so expire stays asserted rather than wrapping.
module pa_watchdog #(
  parameter int unsigned LIMIT = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_reg;

  assign expire = (count_reg == LAST);

  // Count enabled cycles; clear has priority, saturate at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/pa_session_ctrl.sv
// Session scheduler for the Alice/Bob privacy-amplification engines.
// Takes a reconciled-key block, validates its length, launches both engines
// together, collects their finish/fail pulses under a watchdog and reports
// the outcome. Optional feature macro: PA_PINGPONG_EN -- when defined the
// reconciled-key BRAM half select toggles after every successful session;
// when undefined it is tied to half 0.
module pa_session_ctrl
  import pa_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned LEN_MIN        = LEN_MIN_DEF,
  parameter int unsigned LEN_MAX        = LEN_MAX_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_switch,
  input  logic             key_ready,
  input  logic [31:0]      key_length_in,
  output logic             pa_start,
  output logic             pa_abort,
  output logic [31:0]      secretkey_length,
  output logic             reconciled_key_addr_index,
  input  logic             A_pa_finish,
  input  logic             A_pa_fail,
  input  logic             B_pa_finish,
  input  logic             B_pa_fail,
  output logic             key_consumed,
  output logic             session_ok,
  output logic             session_err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  pa_state_e        state_reg, state_next;
  logic [31:0]      len_reg;
  logic [1:0]       err_code_reg;
  logic             a_done_reg, b_done_reg, fail_reg;
  logic [CNT_W-1:0] ok_cnt_reg, err_cnt_reg;

  logic key_accept;
  logic len_ok;
  logic both_done;
  logic wd_clear, wd_enable, wd_expire;

  assign key_accept = (state_reg == WAIT_KEY) && start_switch && key_ready;
  assign len_ok     = len_is_legal(len_reg, 32'(LEN_MIN), 32'(LEN_MAX));
  assign both_done  = a_done_reg && b_done_reg;
  assign wd_clear   = (state_reg == LAUNCH);
  assign wd_enable  = (state_reg == RUN);

  pa_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state output pulses
  always_comb begin
    state_next   = state_reg;
    pa_start     = 1'b0;
    pa_abort     = 1'b0;
    session_ok   = 1'b0;
    session_err  = 1'b0;
    key_consumed = 1'b0;
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start_switch) state_next = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (!start_switch)   state_next = IDLE;
        else if (key_ready)  state_next = CHECK;
      end
      CHECK: begin
        state_next = len_ok ? LAUNCH : ERR;
      end
      LAUNCH: begin
        pa_start   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // Completion wins over the watchdog once both engines are done
        if (both_done) begin
          state_next = fail_reg ? ERR : DONE;
        end else if (wd_expire) begin
          pa_abort   = 1'b1;
          state_next = ERR;
        end
      end
      DONE: begin
        session_ok   = 1'b1;
        key_consumed = 1'b1;
        state_next   = start_switch ? WAIT_KEY : IDLE;
      end
      ERR: begin
        session_err  = 1'b1;
        key_consumed = 1'b1;
        state_next   = start_switch ? WAIT_KEY : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the block length when a key is accepted; held for the session
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg <= '0;
    end else if (key_accept) begin
      len_reg <= key_length_in;
    end
  end

  // Record the failure reason; cleared when the next session begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_code_reg <= ERR_NONE;
    end else if (key_accept) begin
      err_code_reg <= ERR_NONE;
    end else if (state_reg == CHECK && !len_ok) begin
      err_code_reg <= ERR_BAD_LEN;
    end else if (state_reg == RUN) begin
      if (both_done && fail_reg) begin
        err_code_reg <= ERR_ENGINE;
      end else if (!both_done && wd_expire) begin
        err_code_reg <= ERR_TIMEOUT;
      end
    end
  end

  // Engine completion flags: cleared at launch, sticky while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_done_reg <= 1'b0;
      b_done_reg <= 1'b0;
      fail_reg   <= 1'b0;
    end else if (state_reg == LAUNCH) begin
      a_done_reg <= 1'b0;
      b_done_reg <= 1'b0;
      fail_reg   <= 1'b0;
    end else if (state_reg == RUN) begin
      a_done_reg <= a_done_reg | A_pa_finish | A_pa_fail;
      b_done_reg <= b_done_reg | B_pa_finish | B_pa_fail;
      fail_reg   <= fail_reg | A_pa_fail | B_pa_fail;
    end
  end

  // Saturating session outcome counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (state_reg == DONE && ok_cnt_reg != '1) begin
        ok_cnt_reg <= ok_cnt_reg + CNT_W'(1);
      end
      if (state_reg == ERR && err_cnt_reg != '1) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef PA_PINGPONG_EN
  logic idx_reg;

  // Swap BRAM halves after each clean session so the other half can refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      idx_reg <= ~idx_reg;
    end
  end

  assign reconciled_key_addr_index = idx_reg;
`else
  assign reconciled_key_addr_index = 1'b0;
`endif

  assign secretkey_length = len_reg;
  assign err_code         = err_code_reg;
  assign ok_cnt           = ok_cnt_reg;
  assign err_cnt          = err_cnt_reg;

endmodule

// File: tb/tb_pa_session_ctrl.sv
// Directed self-checking bench for pa_session_ctrl (TIMEOUT_CYCLES = 1000).
// Honours PA_PINGPONG_EN for the expected BRAM half select.
module tb_pa_session_ctrl;

  localparam int CW = 16;
`ifdef PA_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_switch = 1'b0;
  logic          key_ready = 1'b0;
  logic [31:0]   key_length_in = '0;
  logic          A_pa_finish = 1'b0, A_pa_fail = 1'b0;
  logic          B_pa_finish = 1'b0, B_pa_fail = 1'b0;
  logic          pa_start, pa_abort, reconciled_key_addr_index;
  logic [31:0]   secretkey_length;
  logic          key_consumed, session_ok, session_err, busy;
  logic [1:0]    err_code;
  logic [CW-1:0] ok_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  // Pulse counters sampled on the falling edge
  int ps_cnt = 0, ok_pulses = 0, kc_pulses = 0, abort_pulses = 0;

  pa_session_ctrl #(
    .TIMEOUT_CYCLES (1000),
    .CNT_W          (CW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start_switch              (start_switch),
    .key_ready                 (key_ready),
    .key_length_in             (key_length_in),
    .pa_start                  (pa_start),
    .pa_abort                  (pa_abort),
    .secretkey_length          (secretkey_length),
    .reconciled_key_addr_index (reconciled_key_addr_index),
    .A_pa_finish               (A_pa_finish),
    .A_pa_fail                 (A_pa_fail),
    .B_pa_finish               (B_pa_finish),
    .B_pa_fail                 (B_pa_fail),
    .key_consumed              (key_consumed),
    .session_ok                (session_ok),
    .session_err               (session_err),
    .err_code                  (err_code),
    .busy                      (busy),
    .ok_cnt                    (ok_cnt),
    .err_cnt                   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      ps_cnt       <= ps_cnt + int'(pa_start);
      ok_pulses    <= ok_pulses + int'(session_ok);
      kc_pulses    <= kc_pulses + int'(key_consumed);
      abort_pulses <= abort_pulses + int'(pa_abort);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_idx;
    int          kc_before;
    int          ok_before;
    int unsigned lens [3];
    exp_idx = 1'b0;
    lens[0] = 32'd1024;     // LEN_MIN
    lens[1] = 32'd1048576;  // LEN_MAX
    lens[2] = 32'd8192;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_pa_start", pa_start, 0);
    check("rst_len", secretkey_length, 0);
    check("rst_ok_cnt", ok_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_code", err_code, 0);
    check("rst_idx", reconciled_key_addr_index, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // ---- session 1: len 4096, A at +100, B at +300 ----
    start_switch = 1'b1;
    tick();
    $display("step: start_switch high, busy=%0b", busy);
    check("wait_busy", busy, 1);
    key_ready = 1'b1; key_length_in = 32'd4096;
    tick();
    key_ready = 1'b0;
    check("s1_len", secretkey_length, 32'd4096);
    check("s1_no_start_yet", pa_start, 0);
    tick();
    $display("step: key 4096 accepted, pa_start=%0b", pa_start);
    check("s1_pa_start", pa_start, 1);
    repeat (99) tick();
    A_pa_finish = 1'b1;
    tick();
    A_pa_finish = 1'b0;
    repeat (199) tick();
    B_pa_finish = 1'b1;
    tick();
    B_pa_finish = 1'b0;
    check("s1_ok_early", session_ok, 0);
    tick();
    $display("step: session 1 done, session_ok=%0b ok_cnt=%0d", session_ok, ok_cnt);
    check("s1_session_ok", session_ok, 1);
    check("s1_key_consumed", key_consumed, 1);
    check("s1_idx_in_done", reconciled_key_addr_index, 0);
    tick();
    if (PP) exp_idx = ~exp_idx;
    check("s1_ok_cnt", ok_cnt, 1);
    check("s1_idx", reconciled_key_addr_index, 32'(exp_idx));
    check("s1_start_pulses", ps_cnt, 1);
    check("s1_busy_wait", busy, 1);

    // ---- bad length 4000 (not word aligned) ----
    key_ready = 1'b1; key_length_in = 32'd4000;
    tick();
    key_ready = 1'b0;
    tick();
    $display("step: len 4000, session_err=%0b err_code=%0d", session_err, err_code);
    check("len4000_err", session_err, 1);
    check("len4000_code", err_code, 1);
    check("len4000_no_start", pa_start, 0);
    tick();
    check("len4000_err_cnt", err_cnt, 1);
    check("len4000_code_held", err_code, 1);
    check("len4000_idx", reconciled_key_addr_index, 32'(exp_idx));

    // ---- bad length 2^21 (above one BRAM half) ----
    key_ready = 1'b1; key_length_in = 32'h0020_0000;
    tick();
    key_ready = 1'b0;
    tick();
    $display("step: len 2^21, session_err=%0b err_code=%0d", session_err, err_code);
    check("len2m_err", session_err, 1);
    check("len2m_code", err_code, 1);
    tick();
    check("len2m_err_cnt", err_cnt, 2);
    check("len2m_no_start", ps_cnt, 1);
    check("len2m_idx", reconciled_key_addr_index, 32'(exp_idx));

    // ---- engine fail: A fails at +50, B finishes at +80 ----
    key_ready = 1'b1; key_length_in = 32'd4096;
    tick();
    key_ready = 1'b0;
    tick();
    check("fail_pa_start", pa_start, 1);
    check("fail_code_cleared", err_code, 0);
    kc_before = kc_pulses;
    repeat (49) tick();
    A_pa_fail = 1'b1;
    tick();
    A_pa_fail = 1'b0;
    start_switch = 1'b0;  // session must still complete
    tick();
    check("fail_not_before_b", session_err, 0);
    repeat (28) tick();
    B_pa_finish = 1'b1;
    tick();
    B_pa_finish = 1'b0;
    check("fail_still_run", session_err, 0);
    tick();
    $display("step: A fail + B finish, session_err=%0b err_code=%0d", session_err, err_code);
    check("fail_session_err", session_err, 1);
    check("fail_code", err_code, 2);
    check("fail_no_ok", session_ok, 0);
    tick();
    check("fail_to_idle", busy, 0);
    check("fail_kc_once", kc_pulses, kc_before + 1);
    check("fail_err_cnt", err_cnt, 3);
    check("fail_idx", reconciled_key_addr_index, 32'(exp_idx));
    start_switch = 1'b1;
    tick();

    // ---- timeout: B never finishes ----
    key_ready = 1'b1; key_length_in = 32'd4096;
    tick();
    key_ready = 1'b0;
    tick();
    check("to_pa_start", pa_start, 1);
    repeat (10) tick();
    A_pa_finish = 1'b1;
    tick();
    A_pa_finish = 1'b0;
    repeat (988) tick();
    check("to_abort_early", pa_abort, 0);
    tick();
    // first RUN cycle is watchdog count 0; abort lands on count 999
    $display("step: watchdog limit reached, pa_abort=%0b", pa_abort);
    check("to_abort", pa_abort, 1);
    check("to_abort_no_err_yet", session_err, 0);
    tick();
    check("to_session_err", session_err, 1);
    check("to_code", err_code, 3);
    check("to_abort_gone", pa_abort, 0);
    tick();
    check("to_err_cnt", err_cnt, 4);
    check("to_abort_once", abort_pulses, 1);

    // ---- three back-to-back sessions, A and B finish together ----
    for (int i = 0; i < 3; i++) begin
      ok_before = ok_pulses;
      key_ready = 1'b1; key_length_in = lens[i];
      tick();
      key_ready = 1'b0;
      tick();
      check("b2b_pa_start", pa_start, 1);
      tick();
      key_ready = 1'b1; key_length_in = 32'd64;  // ignored while running
      tick();
      key_ready = 1'b0;
      check("b2b_len_held", secretkey_length, lens[i]);
      A_pa_finish = 1'b1; B_pa_finish = 1'b1;
      tick();
      A_pa_finish = 1'b0; B_pa_finish = 1'b0;
      check("b2b_ok_early", session_ok, 0);
      tick();
      check("b2b_session_ok", session_ok, 1);
      tick();
      if (PP) exp_idx = ~exp_idx;
      $display("step: b2b session %0d len=%0d idx=%0b", i, lens[i], reconciled_key_addr_index);
      check("b2b_ok_once", ok_pulses, ok_before + 1);
      check("b2b_ok_gone", session_ok, 0);
      check("b2b_idx", reconciled_key_addr_index, 32'(exp_idx));
    end
    check("b2b_ok_cnt", ok_cnt, 4);
    check("b2b_start_pulses", ps_cnt, 6);

    // ---- reset mid-session ----
    key_ready = 1'b1; key_length_in = 32'd4096;
    tick();
    key_ready = 1'b0;
    tick();
    repeat (21) tick();
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    $display("step: reset mid-session, busy=%0b ok_cnt=%0d", busy, ok_cnt);
    check("mid_busy", busy, 0);
    check("mid_ok_cnt", ok_cnt, 0);
    check("mid_err_cnt", err_cnt, 0);
    check("mid_len", secretkey_length, 0);
    check("mid_idx", reconciled_key_addr_index, 0);
    check("mid_abort", pa_abort, 0);
    ok_before = ok_pulses;
    start_switch = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    A_pa_finish = 1'b1; B_pa_finish = 1'b1;
    tick();
    A_pa_finish = 1'b0; B_pa_finish = 1'b0;
    tick();
    tick();
    check("post_busy", busy, 0);
    check("post_ok_cnt", ok_cnt, 0);
    check("post_no_ok", ok_pulses, ok_before);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
